fb_pixel_sink: RTL and testbench

Receiving end of the pixel-write stream produced by the graphics units (sprite draw units emit `x`, `y`, `colour`, `writeEn`). The block clips each write to the 320x240 screen, buffers it in a small FIFO, and drains it into an on-chip 3-bit framebuffer. The framebuffer is shared with a 1-cycle-latency scan-out read port; scan reads have priority over drains. A bulk clear operation fills the whole screen with one colour and pulses `done`.

---
 rtl/fb_pixel_sink_pkg.sv | 31 +++
 rtl/fb_ram.sv | 27 ++
 rtl/fb_pixel_sink.sv | 152 +++++++++++++++
 tb/tb_fb_pixel_sink.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pixel_sink_pkg.sv
// Shared graphics package for the framebuffer pixel sink.
// Holds the screen geometry, framebuffer addressing constants, colour width,
// the pixel-sink FSM state encoding, the queued-pixel record and the linear
// address helper used by the clip/address stage.
package fb_pixel_sink_pkg;

  localparam int H_RES    = 320;
  localparam int V_RES    = 240;
  localparam int FB_SIZE  = H_RES * V_RES;  // 76800
  localparam int FB_AW    = 17;
  localparam int COLOUR_W = 3;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef struct packed {
    logic [FB_AW-1:0]    addr;
    logic [COLOUR_W-1:0] colour;
  } pix_t;

  // y*320 + x built from shifts, carried at full address width.
  function automatic logic [FB_AW-1:0] pix_addr(input logic [8:0] x,
                                                input logic [7:0] y);
    logic [FB_AW-1:0] yw;
    logic [FB_AW-1:0] xw;
    yw = {9'b0, y};
    xw = {8'b0, x};
    return (yw << 8) + (yw << 6) + xw;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port synchronous framebuffer RAM, FB_SIZE x COLOUR_W.
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_data   port A, synchronous write
//   rd_en/rd_addr           port B read request
//   rd_data                 port B read data, one cycle after rd_en
// Contents are never reset.
module fb_ram
  import fb_pixel_sink_pkg::*;
(
  input  logic                clk,
  input  logic                wr_en,
  input  logic [FB_AW-1:0]    wr_addr,
  input  logic [COLOUR_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [FB_AW-1:0]    rd_addr,
  output logic [COLOUR_W-1:0] rd_data
);

  logic [COLOUR_W-1:0] mem [FB_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fb_pixel_sink.sv
// Framebuffer pixel sink: clips incoming pixel writes to the visible screen,
// queues them in a small FIFO and drains them into the on-chip framebuffer.
// Scan-out reads share the RAM and take priority over drains and clears.
// A bulk clear fills the whole screen with one colour and pulses done.
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   writeEn, x_in, y_in, colour_in   pixel write stream
//   scan_req, scan_addr          scan-out read request (linear address)
//   scan_colour, scan_valid      scan-out read response, 1 cycle later
//   clear_req, clear_colour      start a full-screen clear
//   busy                         clearing or FIFO non-empty
//   done                         one-cycle pulse at clear completion
//   overflow                     sticky: an in-range write was dropped
module fb_pixel_sink #(
  parameter int H_RES = fb_pixel_sink_pkg::H_RES,
  parameter int V_RES = fb_pixel_sink_pkg::V_RES,
  parameter int DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  writeEn,
  input  logic [8:0]                            x_in,
  input  logic [7:0]                            y_in,
  input  logic [fb_pixel_sink_pkg::COLOUR_W-1:0] colour_in,
  input  logic                                  scan_req,
  input  logic [fb_pixel_sink_pkg::FB_AW-1:0]   scan_addr,
  output logic [fb_pixel_sink_pkg::COLOUR_W-1:0] scan_colour,
  output logic                                  scan_valid,
  input  logic                                  clear_req,
  input  logic [fb_pixel_sink_pkg::COLOUR_W-1:0] clear_colour,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow
);

  import fb_pixel_sink_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [8:0]       X_LIM     = 9'(H_RES);
  localparam logic [7:0]       Y_LIM     = 8'(V_RES);
  localparam logic [FB_AW-1:0] FB_LIM    = FB_AW'(H_RES * V_RES);
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(H_RES * V_RES - 1);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(DEPTH);

  pix_t                fifo_mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic [0:0]          state;
  logic [FB_AW-1:0]    clr_cnt;
  logic [COLOUR_W-1:0] clr_colour;

  pix_t                pix_p0;
  logic                pix_ok_p0;
  logic                do_pop;
  logic                do_push;
  logic                do_drop;
  logic                clr_start;
  logic                clr_wr;
  logic                clr_last;
  logic                scan_rd_p0;

  logic                ram_we;
  logic [FB_AW-1:0]    ram_waddr;
  logic [COLOUR_W-1:0] ram_wdata;
  logic [COLOUR_W-1:0] ram_q;

  logic                scan_vld_p1;
  logic                scan_hit_p1;

  // Stage p0: clip, address, FIFO/FSM decisions on registered state.
  always_comb begin
    pix_ok_p0  = writeEn && (x_in < X_LIM) && (y_in < Y_LIM);
    pix_p0     = '{addr: pix_addr(x_in, y_in), colour: colour_in};
    do_pop     = (state == ST_RUN) && (count != '0) && !scan_req;
    // A pop in the same cycle frees the slot a full FIFO needs.
    do_push    = pix_ok_p0 && ((count != FULL_CNT) || do_pop);
    do_drop    = pix_ok_p0 && (count == FULL_CNT) && !do_pop;
    clr_start  = (state == ST_RUN) && clear_req;
    clr_wr     = (state == ST_CLEAR) && !scan_req;
    clr_last   = clr_wr && (clr_cnt == LAST_ADDR);
    scan_rd_p0 = scan_req && (scan_addr < FB_LIM);
  end

  always_comb begin
    ram_we    = do_pop || clr_wr;
    ram_waddr = clr_wr ? clr_cnt    : fifo_mem[rd_ptr].addr;
    ram_wdata = clr_wr ? clr_colour : fifo_mem[rd_ptr].colour;
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= pix_p0;
    if (clr_start) clr_colour <= clear_colour;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      state       <= ST_RUN;
      clr_cnt     <= '0;
      overflow    <= 1'b0;
      done        <= 1'b0;
      scan_vld_p1 <= 1'b0;
      scan_hit_p1 <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (clr_start) begin
        state   <= ST_CLEAR;
        clr_cnt <= '0;
      end else if (clr_wr) begin
        if (clr_last) state <= ST_RUN;
        clr_cnt <= clr_cnt + FB_AW'(1);
      end

      // A drop on the clear-start edge still records the lost pixel.
      if (do_drop)        overflow <= 1'b1;
      else if (clr_start) overflow <= 1'b0;

      done        <= clr_last;
      scan_vld_p1 <= scan_req;
      scan_hit_p1 <= scan_rd_p0;
    end
  end

  // Stage p1: RAM read data returns; out-of-range reads report colour 0.
  assign scan_valid  = scan_vld_p1;
  assign scan_colour = scan_hit_p1 ? ram_q : '0;
  assign busy        = (state == ST_CLEAR) || (count != '0);

  fb_ram u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_en   (scan_rd_p0),
    .rd_addr (scan_addr),
    .rd_data (ram_q)
  );

endmodule

// File: tb/tb_fb_pixel_sink.sv
module tb_fb_pixel_sink;

  logic        clk = 1'b0;
  logic        resetn;
  logic        writeEn;
  logic [8:0]  x_in;
  logic [7:0]  y_in;
  logic [2:0]  colour_in;
  logic        scan_req;
  logic [16:0] scan_addr;
  logic [2:0]  scan_colour;
  logic        scan_valid;
  logic        clear_req;
  logic [2:0]  clear_colour;
  logic        busy;
  logic        done;
  logic        overflow;

  always #5 clk = ~clk;

  fb_pixel_sink dut (
    .clk          (clk),
    .resetn       (resetn),
    .writeEn      (writeEn),
    .x_in         (x_in),
    .y_in         (y_in),
    .colour_in    (colour_in),
    .scan_req     (scan_req),
    .scan_addr    (scan_addr),
    .scan_colour  (scan_colour),
    .scan_valid   (scan_valid),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: screen contents plus a bounded queue of pending pixels.
  localparam int SCREEN = 320 * 240;
  int ref_fb [SCREEN];
  bit known  [SCREEN];
  typedef struct { int addr; int col; } mpix_t;
  mpix_t m_q[$];
  bit    m_clearing = 1'b0;
  int    m_clear_n  = 0;
  int    m_clear_col = 0;
  bit    m_overflow = 1'b0;
  bit    m_done     = 1'b0;
  int    exp_scan[$];
  bit    mon_on     = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies the effect of one clock edge with the inputs currently driven.
  task automatic model_edge();
    bit    drain;
    bit    in_range;
    bit    full;
    mpix_t p;
    if (!resetn) begin
      if (m_clearing)
        for (int a = 0; a < m_clear_n; a++) begin
          ref_fb[a] = m_clear_col;
          known[a]  = 1'b1;
        end
      m_q.delete();
      m_clearing = 1'b0;
      m_overflow = 1'b0;
      m_done     = 1'b0;
      exp_scan.delete();
      return;
    end
    m_done = 1'b0;
    if (scan_req) begin
      if (int'(scan_addr) >= SCREEN) exp_scan.push_back(0);
      else if (known[scan_addr])     exp_scan.push_back(ref_fb[scan_addr]);
      else                           exp_scan.push_back(-1);
    end
    drain    = !m_clearing && (m_q.size() > 0) && !scan_req;
    full     = (m_q.size() >= 4);
    in_range = writeEn && (int'(x_in) < 320) && (int'(y_in) < 240);
    if (!m_clearing && clear_req) begin
      m_clearing  = 1'b1;
      m_clear_n   = 0;
      m_clear_col = int'(clear_colour);
      m_overflow  = 1'b0;
    end else if (m_clearing && !scan_req) begin
      m_clear_n++;
      if (m_clear_n == SCREEN) begin
        for (int a = 0; a < SCREEN; a++) begin
          ref_fb[a] = m_clear_col;
          known[a]  = 1'b1;
        end
        m_clearing = 1'b0;
        m_done     = 1'b1;
      end
    end
    if (drain) begin
      p = m_q.pop_front();
      ref_fb[p.addr] = p.col;
      known[p.addr]  = 1'b1;
    end
    if (in_range) begin
      if (!full || drain) begin
        p.addr = int'(y_in) * 320 + int'(x_in);
        p.col  = int'(colour_in);
        m_q.push_back(p);
      end else begin
        m_overflow = 1'b1;
      end
    end
  endtask

  task automatic step(input bit we, input int x, input int y, input int col,
                      input bit sr, input int sa, input bit cr, input int cc);
    writeEn      = we;
    x_in         = x[8:0];
    y_in         = y[7:0];
    colour_in    = col[2:0];
    scan_req     = sr;
    scan_addr    = sa[16:0];
    clear_req    = cr;
    clear_colour = cc[2:0];
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int x, input int y, input int col);
    step(1, x, y, col, 0, 0, 0, 0);
  endtask

  task automatic rd(input int a);
    step(0, 0, 0, 0, 1, a, 0, 0);
  endtask

  // Monitor: compares status flags every cycle and pops scan expectations.
  always @(negedge clk) begin
    if (mon_on) begin
      int e;
      bit exp_v;
      check("busy", int'(busy), int'(m_clearing || (m_q.size() > 0)));
      check("done", int'(done), int'(m_done));
      check("overflow", int'(overflow), int'(m_overflow));
      exp_v = (exp_scan.size() > 0);
      check("scan_valid", int'(scan_valid), int'(exp_v));
      if (exp_v) begin
        e = exp_scan.pop_front();
        if (scan_valid && e >= 0) check("scan_colour", int'(scan_colour), e);
      end
    end
  end

  initial begin
    int done_at;
    bit we;
    bit sr;
    int x, y, sa;

    for (int a = 0; a < SCREEN; a++) begin
      ref_fb[a] = 0;
      known[a]  = 1'b0;
    end
    resetn = 1'b0;
    idle(1);
    mon_on = 1'b1;
    idle(2);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_scan_valid", int'(scan_valid), 0);
    check("rst_scan_colour", int'(scan_colour), 0);
    resetn = 1'b1;
    idle(1);

    // Single write then read-back two cycles later.
    wr(10, 20, 5);
    idle(1);
    rd(6410);
    idle(1);

    // Clipped writes leave RAM and flags untouched.
    wr(0, 0, 2);
    wr(0, 1, 4);
    idle(2);
    wr(320, 0, 7);
    check("clip_busy_x", int'(busy), 0);
    wr(0, 240, 7);
    check("clip_busy_y", int'(busy), 0);
    rd(0);
    rd(320);
    rd(76800);
    idle(1);
    check("clip_overflow", int'(overflow), 0);

    // Fill on sustained scan stalls.
    wr(104, 50, 7);
    idle(2);
    for (int i = 0; i < 10; i++) begin
      if (i < 5) step(1, 100 + i, 50, i + 1, 1, 76800 + i, 0, 0);
      else       step(0, 0, 0, 0, 1, 76800 + i, 0, 0);
    end
    check("stall_overflow", int'(overflow), 1);
    idle(4);
    check("stall_drained", int'(busy), 0);
    for (int i = 0; i < 5; i++) rd(50 * 320 + 100 + i);
    idle(1);

    // Preload a 16x16 block, then randomised traffic on it.
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++) wr(xx, yy, $urandom_range(0, 7));
    idle(2);
    for (int i = 0; i < 400; i++) begin
      we = $urandom_range(0, 1);
      sr = ($urandom_range(0, 3) == 0);
      x  = ($urandom_range(0, 9) == 0) ? $urandom_range(320, 511) : $urandom_range(0, 15);
      y  = ($urandom_range(0, 9) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 15);
      sa = ($urandom_range(0, 9) == 0) ? 76800 + $urandom_range(0, 1000)
                                       : $urandom_range(0, 15) * 320 + $urandom_range(0, 15);
      step(we, x, y, $urandom_range(0, 7), sr, sa, 0, 0);
    end
    idle(6);

    // Full clear to colour 3 with a pixel queued during the clear.
    step(0, 0, 0, 0, 0, 0, 1, 3);
    check("clear_ovf_cleared", int'(overflow), 0);
    done_at = -1;
    for (int c = 1; c <= SCREEN + 10; c++) begin
      if (c == 5)       wr(1, 1, 6);
      else if (c == 10) step(0, 0, 0, 0, 0, 0, 1, 5);
      else              idle(1);
      if (done === 1'b1) begin
        done_at = c;
        break;
      end
    end
    check("clear_cycles", done_at, SCREEN);
    idle(3);
    rd(0);
    rd(38400);
    rd(76799);
    rd(321);
    rd(322);
    idle(2);

    // Reset in the middle of a clear abandons it.
    step(0, 0, 0, 0, 0, 0, 1, 1);
    for (int c = 0; c < 1000; c++) begin
      if (c == 500) wr(7, 7, 2);
      else          idle(1);
    end
    resetn = 1'b0;
    idle(1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    resetn = 1'b1;
    idle(5);
    wr(2, 2, 4);
    idle(1);
    rd(642);
    rd(500);
    rd(2000);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
